load_store_unit: RTL and testbench

Memory-stage load/store unit for the MIPS-32 core, sitting directly upstream of the word-organised data memory. It accepts one load or store per request from the execute stage and sequences the word memory through a small FSM. It extracts and sign- or zero-extends sub-word load data. Sub-word stores (sb/sh) are performed as read-modify-write so the memory only ever sees full-word writes.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store sequencer for a word-organised
// data memory. Sub-word loads are extracted and extended. Sub-word stores
// are done as read-modify-write, so the memory only sees full-word writes.
// Optional feature macro: LSU_ALIGN_CHECK_EN. When it is defined,
// misaligned halfword/word accesses fault with exc and make no memory access.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [5:0]        opcode,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic              busy,
  output logic              done,
  output logic              exc,
  output logic [31:0]       read_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       sdata_q, sdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              exc_q, exc_d;

  logic              legal_op;
  logic              misaligned;
  logic              is_load;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  // Address bits above the memory's word index have no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_W+2];

  // Classify the incoming request: legal opcode and (optionally) alignment.
  always_comb begin
    legal_op   = 1'b0;
    misaligned = 1'b0;
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
`ifdef LSU_ALIGN_CHECK_EN
    if ((opcode == OP_LH || opcode == OP_LHU || opcode == OP_SH) && address[0])
      misaligned = 1'b1;
    if ((opcode == OP_LW || opcode == OP_SW) && (address[1:0] != 2'b00))
      misaligned = 1'b1;
`endif
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane_b   = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h   = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    case (op_q)
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'h000000, lane_b};
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'h0000, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  // Splice the store byte/halfword into the word read back from memory.
  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB)
      merged[{off_q, 3'b000} +: 8] = sdata_q[7:0];
    else
      merged[{off_q[1], 4'b0000} +: 16] = sdata_q;
  end

  // Loads occupy 0x20..0x25 and stores 0x28..0x2B; bit 3 separates them.
  assign is_load = ~op_q[3];

  // Next-state and datapath update for the request sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    sdata_d = sdata_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = opcode;
          waddr_d = address[ADDR_W+1:2];
          off_d   = address[1:0];
          sdata_d = write_data[15:0];
          exc_d   = 1'b0;
          if (!legal_op || misaligned) begin
            exc_d   = 1'b1;
            state_d = S_DONE;
          end else if (opcode == OP_SW) begin
            wdata_d = write_data;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        if (is_load) begin
          rdata_d = load_val;
          state_d = S_DONE;
        end else begin
          wdata_d = merged;
          state_d = S_WR;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      waddr_q <= '0;
      off_q   <= '0;
      sdata_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  // Strobes are decoded from the state and gated by reset, so asserting
  // reset during WR suppresses that write in the same cycle.
  assign busy      = !reset && (state_q != S_IDLE);
  assign done      = !reset && (state_q == S_DONE);
  assign exc       = !reset && (state_q == S_DONE) && exc_q;
  assign mem_rd_en = !reset && (state_q == S_RD);
  assign mem_wr_en = !reset && (state_q == S_WR);
  assign mem_addr  = (!reset && (state_q != S_IDLE)) ? waddr_q : '0;
  assign mem_wdata = wdata_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases followed by random requests,
// checked against a transaction-level model of memory and the load result.
// Follows LSU_ALIGN_CHECK_EN the same way the design does.
module tb_load_store_unit;

  localparam int ADDR_W = 8;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic [5:0]        opcode;
  logic [31:0]       address;
  logic [31:0]       write_data;
  logic              busy, done, exc;
  logic [31:0]       read_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en, mem_wr_en;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .opcode(opcode), .address(address),
    .write_data(write_data), .busy(busy), .done(done), .exc(exc),
    .read_data(read_data), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with a registered read, plus traffic counters.
  logic [31:0] mem [256];
  logic        preload = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  function automatic logic [31:0] init_word(int i);
    if (i == 5) return 32'h8899AABB;
    if (i == 4) return 32'hC2345678;
    return (32'h9E3779B9 * i) ^ 32'h0BADF00D;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_rd_en) begin
        mem_rdata <= mem[mem_addr];
        rd_cnt    <= rd_cnt + 1;
      end
      if (mem_wr_en) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt        <= wr_cnt + 1;
        last_wr_addr  <= mem_addr;
        last_wr_data  <= mem_wdata;
      end
    end
  end

  // Reference state: memory contents and the architecturally visible load result.
  logic [31:0] ref_mem [256];
  logic [31:0] ref_rd;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-request effect, computed from the instruction semantics.
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic ex, output int nrd, output int nwr,
                       output logic [31:0] wdat);
    int w = int'(a[9:2]);
    int k = int'(a[1:0]);
    int h = int'(a[1]);
    logic [31:0] old = ref_mem[w];
    logic [31:0] nw;
    int unsigned part;
    bit mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if ((op == LH || op == LHU || op == SH) && a[0]) mis = 1'b1;
    if ((op == LW || op == SW) && a[1:0] != 2'b00) mis = 1'b1;
`endif
    ex = 1'b0; nrd = 0; nwr = 0; wdat = '0; lat = 1;
    if (!(op inside {LB, LH, LW, LBU, LHU, SB, SH, SW}) || mis) begin
      ex = 1'b1;
    end else if (op == LB || op == LBU) begin
      part = (old >> (8 * k)) & 32'hFF;
      ref_rd = (op == LB && part >= 128) ? part - 256 : part;
      lat = 3; nrd = 1;
    end else if (op == LH || op == LHU) begin
      part = (old >> (16 * h)) & 32'hFFFF;
      ref_rd = (op == LH && part >= 32768) ? part - 65536 : part;
      lat = 3; nrd = 1;
    end else if (op == LW) begin
      ref_rd = old;
      lat = 3; nrd = 1;
    end else begin
      if (op == SB) begin
        nw = (old & ~(32'hFF << (8 * k))) | ((wd & 32'hFF) << (8 * k));
        lat = 4; nrd = 1;
      end else if (op == SH) begin
        nw = (old & ~(32'hFFFF << (16 * h))) | ((wd & 32'hFFFF) << (16 * h));
        lat = 4; nrd = 1;
      end else begin
        nw = wd;
        lat = 2;
      end
      nwr = 1; wdat = nw; ref_mem[w] = nw;
    end
  endtask

  // Issue one request and check latency, exc, read_data and memory traffic.
  task automatic run(input string tag, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input bit hold);
    int lat, nrd, nwr, rd0, wr0, n;
    logic ex;
    logic [31:0] wdat;
    bit seen = 1'b0;
    model(op, a, wd, lat, ex, nrd, nwr, wdat);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; opcode = op; address = a; write_data = wd;
    @(posedge clk);
    n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (!hold) begin
        req = 1'b0; address = $urandom; write_data = $urandom;
      end
      if (done) seen = 1'b1;
    end
    req = 1'b0;
    if (!seen) n = 99;
    check({tag, ".latency"}, n, lat);
    check({tag, ".exc"}, {31'b0, exc}, {31'b0, ex});
    check({tag, ".read_data"}, read_data, ref_rd);
    @(negedge clk);
    check({tag, ".reads"}, rd_cnt - rd0, nrd);
    check({tag, ".writes"}, wr_cnt - wr0, nwr);
    check({tag, ".busy_after"}, {31'b0, busy}, 32'd0);
    if (nwr == 1) begin
      check({tag, ".wr_addr"}, {24'b0, last_wr_addr}, {24'b0, a[9:2]});
      check({tag, ".wr_data"}, last_wr_data, wdat);
    end
    $display("txn %s op=%h addr=%h wd=%h latency=%0d exc=%b read_data=%h",
             tag, op, a, wd, n, exc, read_data);
  endtask

  logic [5:0] op_tab [8];

  initial begin
    int wait_n;
    int wr0;
    bit seen;
    logic [5:0] rop;
    logic [31:0] ra;
    op_tab = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    req = 1'b0; opcode = '0; address = '0; write_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    ref_rd = '0;
    reset = 1'b1; preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
    check("reset.exc", {31'b0, exc}, 32'd0);
    check("reset.strobes", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    check("reset.read_data", read_data, 32'd0);
    check("reset.mem_addr", {24'b0, mem_addr}, 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("lb_0x15", LB, 32'h15, 32'h0, 1'b0);
    check("lb_0x15.value", read_data, 32'hFFFFFFAA);
    run("lbu_0x15", LBU, 32'h15, 32'h0, 1'b0);
    check("lbu_0x15.value", read_data, 32'h000000AA);
    run("sb_0x16", SB, 32'h16, 32'h11, 1'b0);
    check("sb_0x16.word", last_wr_data, 32'h8811AABB);
    run("sw_0x20", SW, 32'h20, 32'hDEADBEEF, 1'b0);
    run("lw_0x20", LW, 32'h20, 32'h0, 1'b0);
    check("lw_0x20.value", read_data, 32'hDEADBEEF);
    run("lh_0x13", LH, 32'h13, 32'h0, 1'b0);
    run("illegal_3f", 6'h3F, 32'h24, 32'h12345678, 1'b0);
    run("sb_held_req", SB, 32'h17, 32'h22, 1'b1);

    // Reset while the FSM is writing must cancel the write.
    wr0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; opcode = SB; address = 32'h14; write_data = 32'h55;
    @(posedge clk);
    wait_n = 0; seen = 1'b0;
    while (!seen && wait_n < 8) begin
      @(negedge clk);
      req = 1'b0;
      wait_n++;
      if (mem_wr_en) seen = 1'b1;
    end
    check("rst_wr.reached_wr", {31'b0, seen}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wr.wr_gated", {31'b0, mem_wr_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wr.outputs", {busy, done, exc, mem_rd_en, mem_wr_en, 27'b0}, 32'd0);
    check("rst_wr.read_data", read_data, 32'd0);
    check("rst_wr.mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_wr.mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    check("rst_wr.no_write", wr_cnt - wr0, 32'd0);
    ref_rd = '0;
    $display("txn reset_in_wr op=%h addr=%h writes=%0d", SB, 32'h14, wr_cnt - wr0);

    for (int t = 0; t < 60; t++) begin
      int sel = $urandom_range(0, 9);
      rop = (sel < 8) ? op_tab[sel] : 6'($urandom_range(0, 63));
      ra = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      run($sformatf("rand%0d", t), rop, ra, $urandom, 1'b0);
    end

    for (int i = 0; i < 16; i++) check($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
